seg7_display_arbiter: RTL
=========================

Name: seg7_display_arbiter

Overview:
- Shares the 4-digit seven-segment display between two requesters: A, the PS/2 mouse packet path, and B, the microprocessor bus-write path.
- Grants ownership with a req/gnt handshake, round-robin arbitration and a minimum anti-preemption hold time.
- Latches the owner's 16-bit value and 4-bit dot mask.
- Runs the digit refresh scheduler that drives the seven-segment decoder (select, nibble and dot).

Parameters:
- REFRESH_DIV, 250000: clk_sys cycles per digit refresh tick (200 Hz at 50 MHz).
- HOLD_TICKS, 200: refresh ticks an owner is protected from preemption (1 s).
- IDLE_VALUE, 16'h0000: value displayed when no requester owns the display.

Ports:
- clk_sys  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- req_a  in  1  requester A wants the display (level)
- upd_a  in  1  requester A load strobe, honoured only while gnt_a=1
- data_a  in  16  requester A value; digit3..digit0 = [15:12]..[3:0]
- dot_a  in  4  requester A dot mask; bit i = digit i
- gnt_a  out  1  A owns the display (registered)
- req_b, upd_b, data_b[15:0], dot_b[3:0], gnt_b: identical for requester B
- owner  out  2  00 idle, 01 A, 10 B
- seg_select  out  2  digit index to the decoder
- bin  out  4  nibble for the current digit
- dot  out  1  dot for the current digit

Behaviour:
- Reset (rst=1 at clk_sys edge) applies the following, including mid-operation; no partial state survives:
  - gnt_a=gnt_b=0, owner=00, state IDLE
  - rr pointer=A, hold_cnt=0, div_cnt=0
  - latch value=IDLE_VALUE, latch dots=0
  - seg_select=0, bin=0, dot=0
- Refresh divider:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - tick is a 1-cycle internal pulse when div_cnt==REFRESH_DIV-1.
  - Each tick increments the internal digit pointer mod 4 (3 wraps to 0).
- Output stage is registered:
  - The cycle after a pointer change: seg_select=pointer, bin=latch nibble[pointer], dot=latch dot[pointer].
  - seg_select, bin and dot are therefore always mutually aligned, with 1-cycle latency from the pointer.
  - A latch change is visible on bin/dot 1 cycle later; no wait for the next tick.
- FSM states: IDLE, OWN_A, OWN_B. gnt_a=(state==OWN_A), gnt_b=(state==OWN_B), owner encodes the state.
- IDLE transitions:
  - Only req_a -> OWN_A; only req_b -> OWN_B.
  - Both -> the requester indicated by the rr pointer.
  - Neither -> stay IDLE.
- On entry to OWN_X: hold_cnt=HOLD_TICKS, rr pointer := the other requester.
- hold_cnt decrements on each tick while above 0; it saturates at 0.
- OWN_X transitions, evaluated every cycle:
  - req_X==0 -> leave immediately, regardless of hold: go to OWN_Y if req_Y, else IDLE.
  - req_X==1, req_Y==1 and hold_cnt==0 -> OWN_Y, a direct swap with no idle cycle; gnt_X falls and gnt_Y rises on the same edge.
  - Otherwise stay in OWN_X.
- Latch update:
  - upd_X with gnt_X==1 in that cycle loads data_X/dot_X on the next edge.
  - upd_X while not granted is ignored.
  - upd on the cycle gnt falls is still accepted, because gnt is 1 in that cycle.
- Entry to IDLE loads latch=IDLE_VALUE and dots=0.
- Entry to OWN_X keeps the prior latch until the first accepted upd_X.
- Simultaneous upd_a and upd_b: only the granted one can apply, so no conflict.
- HOLD_TICKS=0: preemption is allowed at any cycle; the FSM degenerates to pure round-robin on contention.
- Widths:
  - hold_cnt is $clog2(HOLD_TICKS+1) bits, minimum 1.
  - div_cnt is $clog2(REFRESH_DIV) bits, minimum 1.

Test Plan:
(All scenarios use REFRESH_DIV=4 and HOLD_TICKS=3.)
1. Reset with req_a=1 held -> during rst all outputs 0 and owner=00; gnt_a=1 one cycle after rst drops.
2. Refresh scan: grant A, upd_a with data_a=16'h1234 and dot_a=4'b0101 -> seg_select cycles 0,1,2,3,0 every 4 cycles.
   - (bin,dot) reads (4,1),(3,0),(2,1),(1,0), each aligned with its seg_select value.
3. Anti-preemption hold: A owns, B asserts req_b at hold_cnt=3 -> gnt_a stays 1 for 3 ticks.
   - On the edge after hold_cnt reaches 0, gnt_a=0 and gnt_b=1 with no idle cycle.
4. Early release: A owns, req_a drops at hold_cnt=2 with req_b=0 -> next cycle owner=00 and the latch shows IDLE_VALUE.
   - bin=0 from the following cycle.
5. Round-robin: from reset, req_a and req_b both asserted in the same cycle -> A is granted first.
   - Both drop, then both re-assert in the same cycle -> B is granted.
6. Ignored strobe: upd_b with data_b=16'hFFFF while A owns -> display unchanged.
   - upd_a on the final cycle of A's grant (swap edge) -> its value is latched and displayed.

Source files
------------

// File: rtl/seg7_display_arbiter.sv
// Two-requester arbiter for a shared 4-digit seven-segment display.
// Round-robin grant with a preemption hold, value/dot latch, and digit refresh scan.
module seg7_display_arbiter #(
  parameter int unsigned REFRESH_DIV = 250000,
  parameter int unsigned HOLD_TICKS  = 200,
  parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        req_a,
  input  logic        upd_a,
  input  logic [15:0] data_a,
  input  logic [3:0]  dot_a,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic        upd_b,
  input  logic [15:0] data_b,
  input  logic [3:0]  dot_b,
  output logic        gnt_b,
  output logic [1:0]  owner,
  output logic [1:0]  seg_select,
  output logic [3:0]  bin,
  output logic        dot
);

  localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic               rr_b_reg;      // 1: B wins the next contended grant
  logic [1:0]         ptr_reg;
  logic [15:0]        latch_value_reg;
  logic [3:0]         latch_dots_reg;
  logic               tick;
  logic               hold_done;
  logic               enter_own;
  logic               enter_idle;
  logic [3:0]         nib [4];

  // Refresh divider and digit pointer
  assign tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      div_cnt_reg <= '0;
      ptr_reg     <= 2'd0;
    end else begin
      if (tick) begin
        div_cnt_reg <= '0;
        ptr_reg     <= ptr_reg + 2'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
    end
  end

  assign hold_done = (hold_cnt_reg == '0);

  // Ownership FSM: next state
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (req_a && req_b) begin
          state_next = rr_b_reg ? OWN_B : OWN_A;
        end else if (req_a) begin
          state_next = OWN_A;
        end else if (req_b) begin
          state_next = OWN_B;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          state_next = req_b ? OWN_B : IDLE;
        end else if (req_b && hold_done) begin
          state_next = OWN_B;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_next = req_a ? OWN_A : IDLE;
        end else if (req_a && hold_done) begin
          state_next = OWN_A;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign enter_own  = (state_next != IDLE) && (state_next != state_reg);
  assign enter_idle = (state_next == IDLE) && (state_reg != IDLE);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      rr_b_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (enter_own) begin
        hold_cnt_reg <= HOLD_LOAD;
        rr_b_reg     <= (state_next == OWN_A);
      end else if (tick && !hold_done) begin
        hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
      end
    end
  end

  assign gnt_a = (state_reg == OWN_A);
  assign gnt_b = (state_reg == OWN_B);
  assign owner = state_reg;

  // Going idle blanks the display even if the departing owner strobed in that cycle.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      latch_value_reg <= IDLE_VALUE;
      latch_dots_reg  <= 4'b0000;
    end else if (enter_idle) begin
      latch_value_reg <= IDLE_VALUE;
      latch_dots_reg  <= 4'b0000;
    end else if (upd_a && gnt_a) begin
      latch_value_reg <= data_a;
      latch_dots_reg  <= dot_a;
    end else if (upd_b && gnt_b) begin
      latch_value_reg <= data_b;
      latch_dots_reg  <= dot_b;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = latch_value_reg[4*gi +: 4];
    end
  endgenerate

  // Registered decoder feed; select, nibble and dot always move together
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      seg_select <= 2'd0;
      bin        <= 4'd0;
      dot        <= 1'b0;
    end else begin
      seg_select <= ptr_reg;
      bin        <= nib[ptr_reg];
      dot        <= latch_dots_reg[ptr_reg];
    end
  end

endmodule
